// File: rtl/ct_decrypt_serial.sv
// ct_decrypt_serial: slot-serial ciphertext decryption.
// Each slot goes through three single-cycle steps in turn, MUL, SUB and DEC.
//   MUL: p = (A*s) mod Q
//   SUB: d = (B - p) mod Q
//   DEC: m = round(d / DELTA) mod T
// One multiplier is shared across all slots. Each side has a valid/ready handshake.
// in_ct[0] carries the A vector and in_ct[1] carries the B vector.
module ct_decrypt_serial #(
    parameter int N_SLOTS = 8,
    parameter int W_BITS  = 16,
    parameter int Q_MOD   = 7710,
    parameter int T_MOD   = 257,
    parameter int DELTA   = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0][N_SLOTS-1:0][W_BITS-1:0]  in_ct,
    input  logic [N_SLOTS-1:0][W_BITS-1:0]       in_sk,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_SLOTS-1:0][W_BITS-1:0]       out_msg,
    output logic                                 busy
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    localparam logic [2*W_BITS-1:0] Q_WIDE   = (2*W_BITS)'(Q_MOD);
    localparam logic [W_BITS-1:0]   Q_NARROW = W_BITS'(Q_MOD);
    localparam logic [W_BITS-1:0]   DELTA_W  = W_BITS'(DELTA);
    localparam logic [W_BITS-1:0]   HALF_W   = W_BITS'(DELTA / 2);
    localparam logic [W_BITS-1:0]   T_W      = W_BITS'(T_MOD);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_SLOTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        SUB,
        DEC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Registered copy of the accepted job; the input ports may change after acceptance.
    logic [N_SLOTS-1:0][W_BITS-1:0] ct_a;
    logic [N_SLOTS-1:0][W_BITS-1:0] ct_b;
    logic [N_SLOTS-1:0][W_BITS-1:0] sk;

    logic [IDX_W-1:0]               idx;
    logic [W_BITS-1:0]              p_reg;
    logic [W_BITS-1:0]              d_reg;
    logic [N_SLOTS-1:0][W_BITS-1:0] msg_reg;

    logic                           accept;
    logic [W_BITS-1:0]              a_cur;
    logic [W_BITS-1:0]              b_cur;
    logic [W_BITS-1:0]              s_cur;
    logic [2*W_BITS-1:0]            prod;
    logic [W_BITS-1:0]              p_next;
    logic [W_BITS-1:0]              d_next;
    logic [W_BITS-1:0]              r_val;
    logic [W_BITS-1:0]              msg_slot;

    // in_ready is held low while rst is high, so a job offered during reset is never accepted.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_msg   = msg_reg;
    assign accept    = in_valid && in_ready;

    assign a_cur = ct_a[idx];
    assign b_cur = ct_b[idx];
    assign s_cur = sk[idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: three cycles per slot, then hold in DONE until the consumer takes the result
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = MUL;
                end
            end
            MUL: state_next = SUB;
            SUB: state_next = DEC;
            DEC: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-slot arithmetic: full-width product reduced mod Q, modular subtract, rounded divide
    always_comb begin
        prod   = (2*W_BITS)'(a_cur) * (2*W_BITS)'(s_cur);
        p_next = W_BITS'(prod % Q_WIDE);
        if (b_cur >= p_reg) begin
            d_next = b_cur - p_reg;
        end else begin
            d_next = b_cur + Q_NARROW - p_reg;
        end
        r_val    = (d_reg + HALF_W) / DELTA_W;
        msg_slot = (r_val == T_W) ? '0 : r_val;
    end

    // Capture the job operands on acceptance and the intermediate products
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            ct_a <= in_ct[0];
            ct_b <= in_ct[1];
            sk   <= in_sk;
        end
        if (state == MUL) begin
            p_reg <= p_next;
        end
        if (state == SUB) begin
            d_reg <= d_next;
        end
    end

    // Slot index and decoded message. out_msg changes only in DEC and holds between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            msg_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= '0;
                    end
                end
                DEC: begin
                    msg_reg[idx] <= msg_slot;
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_decrypt_serial.sv
// Testbench for ct_decrypt_serial.
// It runs directed decode cases, handshake and reset cases, and random encrypted vectors.
// A scoreboard queue holds the expected messages.
module tb_ct_decrypt_serial;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int Q     = 7710;
    localparam int T     = 257;
    localparam int DELTA = 30;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0][N-1:0][W-1:0] in_ct;
    vec_t                   in_sk;
    logic                   out_valid;
    logic                   out_ready;
    vec_t                   out_msg;
    logic                   busy;

    always #5 clk = ~clk;

    ct_decrypt_serial #(
        .N_SLOTS (N),
        .W_BITS  (W),
        .Q_MOD   (Q),
        .T_MOD   (T),
        .DELTA   (DELTA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ct     (in_ct),
        .in_sk     (in_sk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .busy      (busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    vec_t exp_q[$];
    int   acc_q[$];
    vec_t pend_exp;
    vec_t mon_exp;
    int   last_acc      = 0;
    int   last_acc_prev = 0;
    logic prev_ov       = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = W'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] enc(input int a, input int s, input int m, input int e);
        longint x;
        x = longint'(a) * longint'(s) + longint'(m) * DELTA + e;
        x = x % Q;
        if (x < 0) x += Q;
        return W'(x);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, so handshakes seen here complete on the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(pend_exp);
                acc_q.push_back(cyc + 1);
                last_acc_prev = last_acc;
                last_acc      = cyc + 1;
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) check("spurious_out_valid", 32'(out_valid), 0);
                else check("latency", 32'(cyc - acc_q[0]), 3 * N);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    for (int i = 0; i < N; i++)
                        check($sformatf("slot%0d", i), 32'(out_msg[i]), 32'(mon_exp[i]));
                end
            end
        end
        prev_ov = out_valid;
    end

    // Called one step after a rising edge; returns one step after the accepting edge.
    task automatic send(input vec_t a, input vec_t b, input vec_t s, input vec_t exp);
        int t = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                check("in_ready_timeout", 32'(in_ready), 1);
                return;
            end
        end
        in_ct[0] = a;
        in_ct[1] = b;
        in_sk    = s;
        pend_exp = exp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_ct[0][i] = W'($urandom_range(0, Q - 1));
            in_ct[1][i] = W'($urandom_range(0, Q - 1));
            in_sk[i]    = W'($urandom_range(0, Q - 1));
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(posedge clk); #1;
            t++;
            if (t > 500) begin
                check("drain_timeout", 32'(exp_q.size()), 0);
                exp_q.delete();
                acc_q.delete();
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b, s, e;
        int   t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_ct     = '0;
        in_sk     = '0;
        pend_exp  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_msg", 32'(out_msg[0]), 0);
        rst = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Basic decode: m=5, e=+2
        send(fill(100), fill(452), fill(3), fill(5));
        check("busy_running", 32'(busy), 1);
        check("in_ready_running", 32'(in_ready), 0);
        drain();

        // Negative noise: m=5, e=-3
        send(fill(100), fill(447), fill(3), fill(5));
        drain();

        // Alternating positive and negative noise slots
        for (int i = 0; i < N; i++) b[i] = (i % 2 == 0) ? W'(452) : W'(447);
        send(fill(100), b, fill(3), fill(5));
        drain();

        // Top symbol and mod-T wrap
        send(fill(7709), fill(7678), fill(2), fill(256));
        drain();
        send(fill(0), fill(7700), fill(0), fill(0));
        drain();

        // Back-pressure plus in_valid pulses while busy
        out_ready = 1'b0;
        send(fill(100), fill(3300), fill(3), fill(100));
        for (int k = 0; k < 4; k++) begin
            pend_exp = fill(999);
            in_valid = 1'b1;
            check("pulse_in_ready", 32'(in_ready), 0);
            check("pulse_busy", 32'(busy), 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_msg_first", 32'(out_msg[0]), 100);
            check("bp_msg_last", 32'(out_msg[N-1]), 100);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        check("hold_msg", 32'(out_msg[3]), 100);

        // Back-to-back jobs: handshake period 3*N+2
        send(fill(100), fill(452), fill(3), fill(5));
        send(fill(7709), fill(7678), fill(2), fill(256));
        check("b2b_period", 32'(last_acc - last_acc_prev), 3 * N + 2);
        drain();

        // Reset ten cycles into a job
        send(fill(100), fill(452), fill(3), fill(5));
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready_low", 32'(in_ready), 0);
        check("midrst_out_valid_low", 32'(out_valid), 0);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_msg", 32'(out_msg[0]), 0);
        @(posedge clk); #1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("midrst_no_output", 32'(out_valid), 0);
        for (int i = 0; i < N; i++) begin
            a[i] = W'(1234 + i);
            s[i] = W'(567 * (i + 1));
            e[i] = W'(40 + i);
            b[i] = enc(1234 + i, 567 * (i + 1), 40 + i, (i % 2 == 0) ? 11 : -9);
        end
        send(a, b, s, e);
        drain();

        // Random encrypted vectors, |e| <= 14
        for (int v = 0; v < 200; v++) begin
            for (int i = 0; i < N; i++) begin
                int ai, si, mi, ei;
                ai   = int'($urandom_range(0, Q - 1));
                si   = int'($urandom_range(0, Q - 1));
                mi   = int'($urandom_range(0, T - 1));
                ei   = int'($urandom_range(0, 28)) - 14;
                a[i] = W'(ai);
                s[i] = W'(si);
                e[i] = W'(mi);
                b[i] = enc(ai, si, mi, ei);
            end
            send(a, b, s, e);
        end
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
